bcd_sseg_scan: RTL and testbench
================================

// Module: bcd_sseg_scan
// PURPOSE
//  Downstream display stage for the binary-to-BCD converter. Captures N_DIG packed BCD digits on a
//  load pulse (driven from the converter's done_tick) and time-multiplexes them onto a common
//  seven-segment display. Provides leading-zero blanking, per-digit decimal points, an inter-digit
//  ghosting gap and a frame-complete pulse. All outputs are registered.
// PARAMETERS
//  N_DIG     6      digits scanned (2..8)
//  SHOW_CYC  50000  clk cycles a digit is lit per visit (>=1)
//  GAP_CYC   2000   clk cycles all anodes are off before each digit (>=0; 0 = no gap state)
// PORTS
//  clk      in   1        system clock
//  rst      in   1        synchronous reset, active-high
//  load     in   1        one-cycle capture strobe
//  bcd_in   in   4*N_DIG  packed digits; dig0 in bits [3:0] (LS digit)
//  dp_in    in   N_DIG    decimal point per digit; bit i = digit i
//  lz_en    in   1        1 = blank leading zeros (live input, not captured)
//  an       out  N_DIG    anodes, active-low; bit i = digit i
//  sseg     out  8        segments, active-low, {dp,g,f,e,d,c,b,a}
//  frame_tick out 1       one-cycle pulse per completed scan
// BEHAVIOUR
//  - Reset (on clk edge with rst=1): capture regs 0, dp regs 0, idx 0, state GAP (SHOW if
//    GAP_CYC=0), cycle counter 0, an all 1, sseg 8'hFF, frame_tick 0.
//    Reset mid-scan aborts immediately; the scan restarts at digit 0.
//  - Capture: load=1 at edge k copies bcd_in/dp_in into regs at k. The scan position is not
//    disturbed. New data reaches sseg/an at edge k+1 if the current digit is in SHOW.
//  - FSM per digit idx:
//    - GAP: an all 1, sseg FF for GAP_CYC cycles -> SHOW.
//    - SHOW: SHOW_CYC cycles -> idx=idx+1 (N_DIG-1 wraps to 0) -> GAP (or SHOW if GAP_CYC=0).
//    - Counter width is $clog2(max(SHOW_CYC,GAP_CYC)+1).
//  - Scan period: N_DIG*(SHOW_CYC+GAP_CYC) cycles.
//  - Decode, active-low:
//    - 0..9: C0 F9 A4 B0 99 92 82 F8 80 90.
//    - 10..15: BF ("-", g only).
//    - dp reg set: clear bit 7.
//  - Leading zeros: digit i (i>=1) is blank when lz_en=1 and captured digits i..N_DIG-1 are all 0.
//    - Digit 0 is never blank.
//    - A blank digit without dp keeps its anode off and sseg FF during its SHOW.
//    - A blank digit with dp lights its anode with sseg 7F.
//  - Non-blank digit in SHOW: an = ~(1<<idx); sseg = decoded pattern.
//  - frame_tick: high exactly one cycle, on the first cycle of digit 0's GAP (or SHOW) after a wrap.
//    It never follows reset directly.
//  - load and wrap on the same edge: capture happens and the wrap proceeds normally.
// TESTING (N_DIG=6, SHOW_CYC=4, GAP_CYC=1)
//  1. rst held 3 cycles then released -> an=6'h3F, sseg=FF, frame_tick=0 in reset and in the
//     first GAP; digit0 lit (C0) from cycle 2.
//  2. load bcd 0x001234, dp 0, lz_en=1 -> per frame:
//     - digits 0..3: 4 cycles each, an=~(1<<i), sseg B0? no: digit0=99, d1=B0, d2=A4, d3=F9.
//     - digits 4,5: an=3F, sseg=FF.
//  3. load 0x000000, lz_en=1 -> only digit0 lit (C0). Drop lz_en to 0 -> all six show C0 within
//     one frame.
//  4. load 0x00000A, dp_in=6'b000100 -> digit0 BF; digit2 anode on, sseg 7F (blank digit with dp).
//  5. Free-run -> frame_tick pulses every 30 cycles, 1 cycle wide. load asserted on a wrap edge
//     -> period unchanged, new data in the next frame.
//  6. Reset mid-SHOW of digit3 -> next cycle an=3F, sseg=FF; digit0 shown 2 cycles later;
//     captured data cleared (C0).

Source files
------------

// File: rtl/bcd_sseg_scan_if.sv
// Display-side bundle for bcd_sseg_scan: capture strobe, digit/dp data,
// blanking control and the multiplexed anode/segment outputs.
interface bcd_sseg_scan_if #(
    parameter int N_DIG = 6
);
    logic                 load;
    logic [4*N_DIG-1:0]   bcd_in;
    logic [N_DIG-1:0]     dp_in;
    logic                 lz_en;
    logic [N_DIG-1:0]     an;
    logic [7:0]           sseg;
    logic                 frame_tick;

    modport master (
        output load, bcd_in, dp_in, lz_en,
        input  an, sseg, frame_tick
    );

    modport slave (
        input  load, bcd_in, dp_in, lz_en,
        output an, sseg, frame_tick
    );
endinterface

// File: rtl/bcd_sseg_scan.sv
// Time-multiplexed seven-segment driver: captures packed BCD digits on load and
// scans them with leading-zero blanking, decimal points and an anode-off gap.
module bcd_sseg_scan #(
    parameter int N_DIG    = 6,
    parameter int SHOW_CYC = 50000,
    parameter int GAP_CYC  = 2000
) (
    input  logic            clk,
    input  logic            rst,
    bcd_sseg_scan_if.slave  bus
);
    localparam int MAX_CYC = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = $clog2(N_DIG);
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIG - 1);

    typedef enum logic {GAP, SHOW} state_t;
    localparam state_t START_ST = (GAP_CYC == 0) ? SHOW : GAP;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [4*N_DIG-1:0]   bcd_q;
    logic [N_DIG-1:0]     dp_q;
    logic [N_DIG-1:0]     an_q, an_d;
    logic [7:0]           sseg_q, sseg_d;
    logic                 frame_q, frame_d;
    logic                 wrap;
    logic [N_DIG-1:0]     zero_above;
    logic [3:0]           cur_dig;
    logic                 cur_dp;
    logic                 blank;

    function automatic logic [7:0] seg_decode(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hBF;
        endcase
        return s;
    endfunction

    // Scan sequencer: gap/show dwell per digit, wrap flags the frame boundary
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        wrap    = 1'b0;
        case (state_q)
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = START_ST;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = START_ST;
                cnt_d   = '0;
            end
        endcase
    end

    // zero_above[i]: captured digits i..N_DIG-1 are all zero
    always_comb begin
        zero_above = '1;
        for (int i = 0; i < N_DIG; i++) begin
            for (int j = i; j < N_DIG; j++) begin
                if (bcd_q[4*j +: 4] != 4'd0) begin
                    zero_above[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        cur_dig = bcd_q[int'(idx_q)*4 +: 4];
        cur_dp  = dp_q[idx_q];
        blank   = bus.lz_en && (idx_q != '0) && zero_above[idx_q];
        an_d    = '1;
        sseg_d  = 8'hFF;
        frame_d = wrap;
        if (state_q == SHOW) begin
            if (!blank) begin
                an_d   = ~(N_DIG'(1) << idx_q);
                sseg_d = seg_decode(cur_dig) & (cur_dp ? 8'h7F : 8'hFF);
            end else if (cur_dp) begin
                an_d   = ~(N_DIG'(1) << idx_q);
                sseg_d = 8'h7F;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= START_ST;
            cnt_q   <= '0;
            idx_q   <= '0;
            bcd_q   <= '0;
            dp_q    <= '0;
            an_q    <= '1;
            sseg_q  <= 8'hFF;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            sseg_q  <= sseg_d;
            frame_q <= frame_d;
            if (bus.load) begin
                bcd_q <= bus.bcd_in;
                dp_q  <= bus.dp_in;
            end
        end
    end

    assign bus.an         = an_q;
    assign bus.sseg       = sseg_q;
    assign bus.frame_tick = frame_q;
endmodule

// File: tb/tb_bcd_sseg_scan.sv
// Bench for bcd_sseg_scan (6 digits, 4-cycle show, 1-cycle gap): a frame-position
// reference model predicts an/sseg/frame_tick for every clock.
module tb_bcd_sseg_scan;
    localparam int N = 6;
    localparam int S = 4;
    localparam int G = 1;
    localparam int P = N * (S + G);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_sseg_scan_if #(.N_DIG(N)) bus ();

    bcd_sseg_scan #(.N_DIG(N), .SHOW_CYC(S), .GAP_CYC(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};

    int          tests = 0;
    int          fails = 0;
    int          n     = 0;
    logic [23:0] mbcd  = '0;
    logic [5:0]  mdp   = '0;
    logic [5:0]  e_an;
    logic [7:0]  e_sseg;
    logic        e_ft;

    // Advance one clock; expected outputs come from the frame position before the edge.
    task automatic step();
        int pos, d, ph;
        logic [3:0] v;
        logic blank;
        @(posedge clk);
        if (rst) begin
            e_an = 6'h3F; e_sseg = 8'hFF; e_ft = 1'b0;
            n = 0; mbcd = '0; mdp = '0;
        end else begin
            pos = n % P; d = pos / (S + G); ph = pos % (S + G);
            e_an = 6'h3F; e_sseg = 8'hFF;
            if (ph >= G) begin
                v = mbcd[4*d +: 4];
                blank = bus.lz_en && (d != 0) && ((mbcd >> (4*d)) == 24'd0);
                if (!blank) begin
                    e_an   = ~(6'd1 << d);
                    e_sseg = seg_tab[v] & (mdp[d] ? 8'h7F : 8'hFF);
                end else if (mdp[d]) begin
                    e_an   = ~(6'd1 << d);
                    e_sseg = 8'h7F;
                end
            end
            e_ft = ((n + 1) % P == 0);
            n++;
            if (bus.load) begin
                mbcd = bus.bcd_in;
                mdp  = bus.dp_in;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.load = 1'b0; bus.bcd_in = '0; bus.dp_in = '0; bus.lz_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (bus.an !== 6'h3F || bus.sseg !== 8'hFF || bus.frame_tick !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold cyc=%0d an=%h sseg=%h ft=%b want 3F/FF/0", i, bus.an, bus.sseg, bus.frame_tick);
            end
        end
        rst = 1'b0;
        step();
        tests++;
        if (bus.an !== 6'h3F || bus.sseg !== 8'hFF || bus.frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL first_gap an=%h sseg=%h ft=%b want 3F/FF/0", bus.an, bus.sseg, bus.frame_tick);
        end
        step();
        tests++;
        if (bus.an !== 6'h3E || bus.sseg !== 8'hC0) begin
            fails++;
            $display("FAIL first_digit0 an=%h sseg=%h want 3E/C0", bus.an, bus.sseg);
        end
    endtask

    task automatic test_lz_scan();
        bus.bcd_in = 24'h001234; bus.dp_in = '0; bus.lz_en = 1'b1; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        for (int i = 0; i < 2*P; i++) begin
            step();
            tests++;
            if (bus.an !== e_an || bus.sseg !== e_sseg || bus.frame_tick !== e_ft) begin
                fails++;
                $display("FAIL lz_scan n=%0d an=%h/%h sseg=%h/%h ft=%b/%b", n, bus.an, e_an, bus.sseg, e_sseg, bus.frame_tick, e_ft);
            end
        end
    endtask

    task automatic test_all_zero();
        bus.bcd_in = 24'h000000; bus.dp_in = '0; bus.lz_en = 1'b1; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        for (int i = 0; i < 2*P; i++) begin
            if (i == P) bus.lz_en = 1'b0;
            step();
            tests++;
            if (bus.an !== e_an || bus.sseg !== e_sseg || bus.frame_tick !== e_ft) begin
                fails++;
                $display("FAIL all_zero n=%0d an=%h/%h sseg=%h/%h ft=%b/%b", n, bus.an, e_an, bus.sseg, e_sseg, bus.frame_tick, e_ft);
            end
        end
    endtask

    task automatic test_dp_blank();
        bus.bcd_in = 24'h00000A; bus.dp_in = 6'b000100; bus.lz_en = 1'b1; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        for (int i = 0; i < P + 2; i++) begin
            step();
            tests++;
            if (bus.an !== e_an || bus.sseg !== e_sseg || bus.frame_tick !== e_ft) begin
                fails++;
                $display("FAIL dp_blank n=%0d an=%h/%h sseg=%h/%h ft=%b/%b", n, bus.an, e_an, bus.sseg, e_sseg, bus.frame_tick, e_ft);
            end
        end
    endtask

    task automatic test_load_on_wrap();
        int last_tick = -1;
        int cyc = 0;
        for (int i = 0; i < P && (n % P) != P - 1; i++) step();
        bus.bcd_in = 24'h987650; bus.dp_in = 6'b100001; bus.lz_en = 1'b0; bus.load = 1'b1;
        for (int i = 0; i < 3*P; i++) begin
            step();
            bus.load = 1'b0;
            cyc++;
            tests++;
            if (bus.an !== e_an || bus.sseg !== e_sseg || bus.frame_tick !== e_ft) begin
                fails++;
                $display("FAIL load_on_wrap n=%0d an=%h/%h sseg=%h/%h ft=%b/%b", n, bus.an, e_an, bus.sseg, e_sseg, bus.frame_tick, e_ft);
            end
            if (bus.frame_tick === 1'b1) begin
                if (last_tick >= 0) begin
                    tests++;
                    if (cyc - last_tick !== P) begin
                        fails++;
                        $display("FAIL tick_period got=%0d want=%0d", cyc - last_tick, P);
                    end
                end
                last_tick = cyc;
            end
        end
    endtask

    task automatic test_random();
        logic [23:0] v;
        for (int i = 0; i < 20*P; i++) begin
            bus.load = ($urandom_range(0, 19) == 0);
            if (bus.load) begin
                for (int d = 0; d < N; d++)
                    v[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                bus.bcd_in = v;
                bus.dp_in  = 6'($urandom_range(0, 63)) & 6'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 49) == 0) bus.lz_en = ~bus.lz_en;
            step();
            tests++;
            if (bus.an !== e_an || bus.sseg !== e_sseg || bus.frame_tick !== e_ft) begin
                fails++;
                $display("FAIL random n=%0d an=%h/%h sseg=%h/%h ft=%b/%b", n, bus.an, e_an, bus.sseg, e_sseg, bus.frame_tick, e_ft);
            end
        end
        bus.load = 1'b0;
    endtask

    task automatic test_mid_reset();
        bus.bcd_in = 24'h123456; bus.dp_in = '0; bus.lz_en = 1'b0; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        for (int i = 0; i < 2*P && (n % P) != 3*(S+G) + G + 1; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if (bus.an !== 6'h3F || bus.sseg !== 8'hFF || bus.frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset an=%h sseg=%h ft=%b want 3F/FF/0", bus.an, bus.sseg, bus.frame_tick);
        end
        step();
        tests++;
        if (bus.an !== 6'h3F || bus.sseg !== 8'hFF) begin
            fails++;
            $display("FAIL mid_reset_gap an=%h sseg=%h want 3F/FF", bus.an, bus.sseg);
        end
        step();
        tests++;
        if (bus.an !== 6'h3E || bus.sseg !== 8'hC0) begin
            fails++;
            $display("FAIL mid_reset_cleared an=%h sseg=%h want 3E/C0", bus.an, bus.sseg);
        end
        for (int i = 0; i < P + 3; i++) begin
            step();
            tests++;
            if (bus.an !== e_an || bus.sseg !== e_sseg || bus.frame_tick !== e_ft) begin
                fails++;
                $display("FAIL after_reset n=%0d an=%h/%h sseg=%h/%h ft=%b/%b", n, bus.an, e_an, bus.sseg, e_sseg, bus.frame_tick, e_ft);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lz_scan();
        test_all_zero();
        test_dp_blank();
        test_load_on_wrap();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
